// File: rtl/control_unit.sv
// Hardwired control unit for the multi-cycle datapath: fetch T0-T2, then per-opcode execute
// steps T3-T7 decoded from the state register and the opcode held in IRout.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IRout,
    input  logic        conOut,
    input  logic        stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLOout,
    output logic        CSignout,
    output logic        ZMuxOut,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLOin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        conin,
    output logic        read,
    output logic        write,
    output logic        RAMenable,
    output logic        ZMuxEnable,
    output logic        ZSelect,
    output logic [4:0]  aluControl,
    output logic        run,
    output logic        illegal
);
    typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state;
    logic [4:0] op;
    logic       isAlu, isImm, isMem, legal;
    state_t     endState;
    logic       unusedIr;

    assign op       = IRout[31:27];
    assign unusedIr = ^IRout[26:0];
    assign isAlu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign isImm    = (op == OP_ADDI) || (op == OP_LDI);
    assign isMem    = (op == OP_LD) || (op == OP_ST);
    assign legal    = isAlu || isImm || isMem || (op == OP_BR) || (op == OP_JR) ||
                      (op == OP_NOP) || (op == OP_HALT);
    // stop only matters on the last step of an instruction
    assign endState = stop ? HALT : T0;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= RESET;
        end else begin
            case (state)
                RESET: state <= T0;
                T0:    state <= T1;
                T1:    state <= T2;
                T2:    state <= T3;
                T3: begin
                    if (op == OP_HALT)                               state <= HALT;
                    else if (op == OP_JR || op == OP_NOP || !legal)  state <= endState;
                    else                                             state <= T4;
                end
                T4:    state <= T5;
                T5:    state <= (isAlu || isImm) ? endState : T6;
                T6:    state <= (op == OP_BR) ? endState : T7;
                T7:    state <= endState;
                HALT:  state <= HALT;
                default: state <= RESET;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; MDRout = 1'b0; ZLOout = 1'b0; CSignout = 1'b0; ZMuxOut = 1'b0;
        PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        ZLOin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; conin = 1'b0; read = 1'b0; write = 1'b0; RAMenable = 1'b0;
        ZMuxEnable = 1'b0; ZSelect = 1'b0; aluControl = 5'b00000; illegal = 1'b0;
        run = (state != RESET) && (state != HALT);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (isAlu || op == OP_ADDI) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (op == OP_LDI || isMem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (op == OP_BR) begin
                    Gra = 1'b1; Rout = 1'b1; conin = 1'b1;
                end else if (op == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (!legal) begin
                    illegal = 1'b1;
                end
            end
            T4: begin
                if (isAlu) begin
                    Grc = 1'b1; Rout = 1'b1; aluControl = op;
                    ZMuxEnable = 1'b1; ZMuxOut = 1'b1; ZLOin = 1'b1;
                end else if (isImm || isMem) begin
                    CSignout = 1'b1; aluControl = OP_ADD;
                    ZMuxEnable = 1'b1; ZMuxOut = 1'b1; ZLOin = 1'b1;
                end else if (op == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            T5: begin
                if (isAlu || isImm) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (isMem) begin
                    ZLOout = 1'b1; MARin = 1'b1;
                end else if (op == OP_BR) begin
                    // branch target = PC + sign-extended displacement
                    CSignout = 1'b1; aluControl = OP_ADD;
                    ZMuxEnable = 1'b1; ZMuxOut = 1'b1; ZLOin = 1'b1;
                end
            end
            T6: begin
                if (op == OP_LD) begin
                    read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
                end else if (op == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (op == OP_BR && conOut) begin
                    ZLOout = 1'b1; PCin = 1'b1;
                end
            end
            T7: begin
                if (op == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_ST) begin
                    write = 1'b1; RAMenable = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  input  1  rising-edge system clock; sole clock of the block.
REQ-002 clear  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-003 IRout  input  32  instruction register contents; opcode = IRout[31:27].
REQ-004 conOut  input  1  registered branch-condition flag from the datapath CON flip-flop.
REQ-005 stop  input  1  level request to halt once the current instruction completes.
REQ-006 PCout, MDRout, ZLOout, CSignout, ZMuxOut  output  1 each  bus-drive selects.
REQ-007 PCin, IncPC, MARin, MDRin, IRin, Yin, ZLOin  output  1 each  register load enables.
REQ-008 Gra, Grb, Grc, Rin, Rout, BAout, conin  output  1 each  select-and-encode and CON controls.
REQ-009 read, write, RAMenable  output  1 each  memory strobes.
REQ-010 ZMuxEnable, ZSelect  output  1 each  ALU result mux controls; ZSelect is always 0 (low word).
REQ-011 aluControl  output  5  ALU operation code.
REQ-012 run  output  1  high in every state except HALT and RESET.
REQ-013 illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-014 Moore FSM; outputs decode from the state register, plus IRout in T3-T7. The only exception is REQ-025.
REQ-015 States: RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT; one state per clock.
REQ-016 Unlisted outputs are 0 in every state. aluControl defaults to 00000.
REQ-017 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01000, br 10010, jr 10100, nop 11010, halt 11011.
REQ-018 ALU ops drive aluControl = opcode. Address and immediate adds drive aluControl = 00011.
REQ-019 Fetch sequence:
- RESET -> T0 unconditionally.
- T0: PCout, MARin, IncPC.
- T1: read, RAMenable, MDRin.
- T2: MDRout, IRin.
- T2 -> T3.
REQ-020 add/sub/and/or:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, aluControl=opcode, ZMuxEnable, ZMuxOut, ZLOin.
- T5: ZLOout, Gra, Rin; then end of instruction.
REQ-021 addi:
- T3: Grb, Rout, Yin.
- T4: CSignout, ADD, ZMuxEnable, ZMuxOut, ZLOin.
- T5: ZLOout, Gra, Rin; then end.
REQ-022 ldi: T3 is Grb, BAout, Yin; T4 and T5 are as addi; then end.
REQ-023 ld:
- T3 and T4: as ldi.
- T5: ZLOout, MARin.
- T6: read, RAMenable, MDRin.
- T7: MDRout, Gra, Rin; then end.
REQ-024 st:
- T3-T5: as ld.
- T6: Gra, Rout, MDRin (read=0).
- T7: write, RAMenable; then end.
REQ-025 br:
- T3: Gra, Rout, conin.
- T4: PCout, Yin.
- T5: CSignout, ADD, ZMuxEnable, ZMuxOut, ZLOin.
- T6: ZLOout and PCin, asserted only if conOut=1; then end.
REQ-026 jr: T3 is Gra, Rout, PCin; then end.
REQ-027 nop ends at T3 with no strobes.
REQ-028 Illegal opcode: T3 pulses illegal and ends like nop.
REQ-029 halt: T3 -> HALT. HALT holds until clear=0; all strobes stay 0 in HALT.
REQ-030 End of instruction: next state is T0 if stop=0, otherwise HALT. stop is sampled only on the last state of an instruction.
REQ-031 Latencies:
- ALU ops: 6 cycles, T0-T5.
- ld/st: 8 cycles.
- br: 7 cycles.
- jr/nop: 4 cycles.
REQ-032 read and write are never high in the same cycle; RAMenable is high only with one of them.

Reset
REQ-033 clear=0 at a rising edge forces RESET from any state, including mid-instruction and HALT. Pending stop and partial state are discarded.
REQ-034 In RESET, every output is 0, including run and illegal.
REQ-035 clear=0 held for N edges keeps the block in RESET. The first edge with clear=1 moves it to T0.

Verification
REQ-036 Release clear; IR loaded with add opcode 00011 -> T0 asserts PCout/MARin/IncPC; T4 asserts aluControl=00011 and ZLOin; T5 asserts Gra/Rin; the next T0 is 6 cycles after the first.
REQ-037 ld, opcode 00000 -> T5 asserts MARin; T6 asserts read=1, RAMenable=1, write=0; T7 asserts MDRout and Rin.
REQ-038 st, opcode 00010 -> T6 asserts MDRin with read=0; T7 asserts write=1, RAMenable=1, read=0.
REQ-039 br with conOut=1 -> T6 asserts PCin and ZLOout. Same with conOut=0 -> T6 asserts no strobes; the next T0 is 7 cycles after fetch start either way.
REQ-040 halt opcode 11011 -> run falls after T3 and stays 0 for 20 cycles. Then clear=0 for one edge -> RESET, then T0 with run=1.
REQ-041 Further directed cases:
- clear=0 asserted during ld T6 -> next cycle all outputs 0.
- stop=1 raised during add T4 -> HALT after T5.
- Opcode 11111 -> illegal is high for exactly one cycle.
